// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge:
// register offsets, status bit positions and the TX launch FSM encoding.
package uart_mmio_pkg;

    // Word offsets within the peripheral window
    localparam logic [2:0] RX_DATA_OFF   = 3'd0;
    localparam logic [2:0] RX_READY_OFF  = 3'd1;
    localparam logic [2:0] CLEAN_RX_OFF  = 3'd2;
    localparam logic [2:0] TX_DATA_OFF   = 3'd3;
    localparam logic [2:0] TX_STATUS_OFF = 3'd4;
    localparam logic [2:0] OVR_CNT_OFF   = 3'd5;

    // RX_READY read fields
    localparam int RDY_NOT_EMPTY_BIT = 0;
    localparam int RDY_OVERRUN_BIT   = 1;
    localparam int RDY_COUNT_LSB     = 8;

    // CLEAN_RX write fields
    localparam int CLR_POP_BIT       = 0;
    localparam int CLR_OVERRUN_BIT   = 1;
    localparam int CLR_OVR_CNT_BIT   = 2;

    // TX_STATUS fields
    localparam int TXS_BUSY_BIT      = 0;
    localparam int TXS_COLLISION_BIT = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_bridge_rx_fifo.sv
// Receive FIFO for the UART MMIO bridge. Circular buffer with
// occupancy count; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle, otherwise it is reported on o_drop.
module uart_rx_fifo
    import uart_mmio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop & ~w_empty;
    // When full, a same-cycle pop vacates the slot the write pointer aliases
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    assign o_head    = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
    assign o_drop    = i_push & ~w_push_ok;

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART byte bridge: register decode, RX FIFO status,
// TX launch FSM with busy tracking and collision/overrun sticky flags.
// Optional dropped-byte counter at offset 5 is built when
// UART_OVERRUN_CNT_EN is defined; otherwise offset 5 reads 0.
//
//   state     | meaning
//   IDLE      | no transfer, TX_DATA write launches
//   LAUNCH    | tx_start asserted for this single cycle
//   WAIT_BUSY | waiting for serializer to raise tx_busy
//   WAIT_DONE | waiting for serializer to drop tx_busy
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        bus_addr,
    input  logic              bus_we,
    input  logic              bus_re,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    input  logic              rx_byte_valid,
    input  logic [DATA_W-1:0] rx_byte,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_byte,
    input  logic              tx_busy
);

    tx_state_t         r_state;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_byte;
    logic              r_collision;
    logic              r_overrun;
    logic [31:0]       r_rdata;

    logic              w_clean_wr;
    logic              w_tx_data_wr;
    logic              w_tx_status_wr;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_drop;
    logic [31:0]       w_rd_mux;
    logic              w_unused_wdata;

    assign w_clean_wr     = bus_we && (bus_addr == CLEAN_RX_OFF);
    assign w_tx_data_wr   = bus_we && (bus_addr == TX_DATA_OFF);
    assign w_tx_status_wr = bus_we && (bus_addr == TX_STATUS_OFF);
    assign w_pop          = w_clean_wr && bus_wdata[CLR_POP_BIT];
    assign w_unused_wdata = ^bus_wdata[31:DATA_W] ^ w_full;

    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (rx_byte_valid),
        .i_pop   (w_pop),
        .i_data  (rx_byte),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    // Sticky overrun: a fresh drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (w_clean_wr && bus_wdata[CLR_OVERRUN_BIT]) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_OVERRUN_CNT_EN
    logic [15:0] r_ovr_cnt;

    // Saturating dropped-byte counter; an explicit clear wins over a drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovr_cnt <= 16'h0000;
        end else if (w_clean_wr && bus_wdata[CLR_OVR_CNT_BIT]) begin
            r_ovr_cnt <= 16'h0000;
        end else if (w_drop && (r_ovr_cnt != 16'hFFFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 16'h0001;
        end
    end
`endif

    // TX launch FSM with registered start pulse, byte and collision flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_tx_start  <= 1'b0;
            r_tx_byte   <= '0;
            r_collision <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            if (w_tx_status_wr && bus_wdata[TXS_COLLISION_BIT]) begin
                r_collision <= 1'b0;
            end
            if (w_tx_data_wr && (r_state != IDLE)) begin
                r_collision <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_tx_data_wr) begin
                        r_tx_byte  <= bus_wdata[DATA_W-1:0];
                        r_tx_start <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read mux over pre-write state
    always_comb begin
        w_rd_mux = 32'h0;
        case (bus_addr)
            RX_DATA_OFF: begin
                if (!w_empty) begin
                    w_rd_mux[DATA_W-1:0] = w_head;
                end
            end
            RX_READY_OFF: begin
                w_rd_mux[RDY_NOT_EMPTY_BIT]         = ~w_empty;
                w_rd_mux[RDY_OVERRUN_BIT]           = r_overrun;
                w_rd_mux[RDY_COUNT_LSB +: CNT_W]    = w_count;
            end
            TX_STATUS_OFF: begin
                w_rd_mux[TXS_BUSY_BIT]      = (r_state != IDLE);
                w_rd_mux[TXS_COLLISION_BIT] = r_collision;
            end
`ifdef UART_OVERRUN_CNT_EN
            OVR_CNT_OFF: begin
                w_rd_mux[15:0] = r_ovr_cnt;
            end
`endif
            default: begin
                w_rd_mux = 32'h0;
            end
        endcase
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= 32'h0;
        end else if (bus_re) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign bus_rdata = r_rdata;
    assign tx_start  = r_tx_start;
    assign tx_byte   = r_tx_byte;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: a driver updates a queue-based
// reference model and pushes expected read data / launch bytes; a monitor
// pops and compares whenever the DUT returns read data or pulses tx_start.
module tb_uart_mmio_bridge;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 3;

    logic              clk;
    logic              reset;
    logic [2:0]        bus_addr;
    logic              bus_we;
    logic              bus_re;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              rx_byte_valid;
    logic [DATA_W-1:0] rx_byte;
    logic              tx_start;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_ovr;
    bit          m_coll;
    int          m_phase;      // 0 idle, 1 launching, 2 awaiting busy, 3 awaiting done
    int unsigned m_ovr_cnt;

    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    int          launches_exp = 0;
    int          launches_seen = 0;
    int          ser_left = 0;
    int          ser_len  = 3;

    uart_mmio_bridge #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .tx_start      (tx_start),
        .tx_byte       (tx_byte),
        .tx_busy       (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            3'd0: if (m_q.size() > 0) v = {24'h0, m_q[0]};
            3'd1: v = (32'(m_q.size()) << 8) | (32'(m_ovr) << 1) | 32'(m_q.size() != 0);
            3'd4: v = (32'(m_coll) << 1) | 32'(m_phase != 0);
            3'd5: begin
`ifdef UART_OVERRUN_CNT_EN
                v = 32'(m_ovr_cnt);
`endif
            end
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovr     = 0;
        m_coll    = 0;
        m_phase   = 0;
        m_ovr_cnt = 0;
        ser_left  = 0;
    endtask

    task automatic model_edge(input logic [2:0] a, input logic we, input logic [31:0] wd,
                              input logic rv, input logic [7:0] rb, input logic busy);
        bit drop;
        bit clean;
        bit txw;
        int ph;
        drop  = 0;
        clean = we && (a == 3'd2);
        txw   = we && (a == 3'd3);
        ph    = m_phase;
        if (clean && wd[0] && m_q.size() > 0) void'(m_q.pop_front());
        if (rv) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(rb);
            else drop = 1;
        end
        if (drop) m_ovr = 1;
        else if (clean && wd[1]) m_ovr = 0;
        if (clean && wd[2]) m_ovr_cnt = 0;
        else if (drop && m_ovr_cnt < 32'hFFFF) m_ovr_cnt++;
        if (ph == 0) begin
            if (txw) begin
                m_phase = 1;
                exp_tx.push_back(wd[7:0]);
                launches_exp++;
            end
        end else begin
            if (txw) m_coll = 1;
            if (ph == 1) m_phase = 2;
            else if (ph == 2 && busy) m_phase = 3;
            else if (ph == 3 && !busy) m_phase = 0;
        end
        if (we && a == 3'd4 && wd[1]) m_coll = 0;
    endtask

    task automatic step(input logic [2:0] a, input logic we, input logic re,
                        input logic [31:0] wd, input logic rv, input logic [7:0] rb);
        int ph;
        @(negedge clk);
        bus_addr      = a;
        bus_we        = we;
        bus_re        = re;
        bus_wdata     = wd;
        rx_byte_valid = rv;
        rx_byte       = rb;
        tx_busy       = (ser_left > 0);
        if (re) exp_rd.push_back(model_read(a));
        ph = m_phase;
        model_edge(a, we, wd, rv, rb, tx_busy);
        if (ser_left > 0) ser_left--;
        if (ph == 1) ser_left = ser_len;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [2:0] a);
        step(a, 1'b0, 1'b1, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d, 1'b0, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        step(3'd0, 1'b0, 1'b0, 32'h0, 1'b1, b);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares read returns and launch pulses against the scoreboard
    initial begin
        bit rd_pend;
        bit prev_start;
        logic [31:0] e;
        prev_start = 0;
        forever begin
            @(posedge clk);
            rd_pend = (bus_re === 1'b1) && (reset === 1'b1);
            @(negedge clk);
            if (rd_pend) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read", 32'h1, 32'h0);
                end else begin
                    e = exp_rd.pop_front();
                    check("read_data", bus_rdata, e);
                end
            end
            if (tx_start === 1'b1) begin
                launches_seen++;
                check("tx_start_single_cycle", 32'(prev_start), 32'h0);
                if (exp_tx.size() == 0) begin
                    check("unexpected_tx_start", 32'h1, 32'h0);
                end else begin
                    e = {24'h0, exp_tx.pop_front()};
                    check("tx_byte", {24'h0, tx_byte}, e);
                end
            end
            prev_start = (tx_start === 1'b1);
        end
    end

    initial begin
        logic [2:0]  a;
        logic        we, re, rv;
        logic [31:0] wd;
        logic [7:0]  rb;

        reset = 1'b0;
        bus_addr = 3'd0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = 32'h0;
        rx_byte_valid = 1'b0; rx_byte = '0; tx_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rdata", bus_rdata, 32'h0);
        check("reset_tx_start", {31'h0, tx_start}, 32'h0);
        check("reset_tx_byte", {24'h0, tx_byte}, 32'h0);
        reset = 1'b1;

        // Basic RX path
        rd(3'd1);
        push(8'h0F);
        rd(3'd0);
        rd(3'd1);
        wr(3'd2, 32'h1);
        rd(3'd1);

        // Overfill by one, then drain
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd(3'd1);
        for (int i = 0; i < 4; i++) begin
            rd(3'd0);
            wr(3'd2, 32'h1);
        end
        rd(3'd0);
        rd(3'd1);
        wr(3'd2, 32'h1);   // pop on empty
        rd(3'd1);
        rd(3'd5);
        wr(3'd2, 32'h6);   // clear overrun and drop counter
        rd(3'd1);
        rd(3'd5);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        step(3'd2, 1'b1, 1'b0, 32'h1, 1'b1, 8'hAA);
        rd(3'd1);
        for (int i = 0; i < 4; i++) begin
            rd(3'd0);
            wr(3'd2, 32'h1);
        end
        rd(3'd1);
        // Read and pop in the same cycle returns pre-pop state
        push(8'h77);
        step(3'd1, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00);
        step(3'd2, 1'b1, 1'b1, 32'h1, 1'b0, 8'h00);
        rd(3'd1);

        // TX launch and collision
        ser_len = 6;
        rd(3'd4);
        wr(3'd3, 32'h41);
        idle(2);
        wr(3'd3, 32'h42);
        rd(3'd4);
        for (int i = 0; i < 20 && m_phase != 0; i++) idle(1);
        rd(3'd4);
        wr(3'd4, 32'h2);
        rd(3'd4);
        rd(3'd7);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            a  = 3'($urandom_range(0, 9) > 7 ? 2 : $urandom_range(0, 7));
            we = ($urandom_range(0, 3) == 0);
            re = $urandom_range(0, 1) == 1;
            wd = $urandom;
            rv = ($urandom_range(0, 4) == 0);
            rb = 8'($urandom);
            ser_len = $urandom_range(1, 5);
            step(a, we, re, wd, rv, rb);
        end
        idle(12);

        // Reset while waiting for the serializer to finish
        ser_len = 8;
        wr(3'd2, 32'h1);
        push(8'h33);
        wr(3'd3, 32'h5A);
        for (int i = 0; i < 10 && m_phase != 3; i++) idle(1);
        rd(3'd4);
        idle(2);
        @(negedge clk);
        #2;
        reset = 1'b0;
        tx_busy = 1'b0;
        #1;
        check("midreset_rdata", bus_rdata, 32'h0);
        check("midreset_tx_start", {31'h0, tx_start}, 32'h0);
        check("midreset_tx_byte", {24'h0, tx_byte}, 32'h0);
        model_reset();
        exp_rd.delete();
        exp_tx.delete();
        repeat (2) @(negedge clk);
        check("held_reset_tx_start", {31'h0, tx_start}, 32'h0);
        reset = 1'b1;
        rd(3'd4);
        rd(3'd1);
        rd(3'd5);
        rd(3'd0);
        idle(4);

        check("pending_reads", 32'(exp_rd.size()), 32'h0);
        check("pending_launches", 32'(exp_tx.size()), 32'h0);
        check("launch_count", 32'(launches_seen), 32'(launches_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
